// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-state encoding, instruction field positions and widths
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int IMM_W = 16;
  typedef enum logic [1:0] {FS_IDLE = 2'd0, FS_FETCH = 2'd1, FS_VALID = 2'd2} fs_t;
  localparam int OPC_HI = 31, OPC_LO = 26;
  localparam int RS_HI = 25, RS_LO = 21;
  localparam int RT_HI = 20, RT_LO = 16;
  localparam int RD_HI = 15, RD_LO = 11;
  localparam int SH_HI = 10, SH_LO = 6;
  localparam int FN_HI = 5, FN_LO = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;
  localparam int JA_HI = 25, JA_LO = 0;
endpackage

// File: rtl/instr_fields.sv
// instr_fields: slices an instruction word into its decode fields
module instr_fields
  import cpu_pkg::*;
(
  input  logic [WORD_W-1:0] ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [IMM_W-1:0]  imm16,
  output logic [25:0]       jaddr
);
  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign shamt  = ir[SH_HI:SH_LO];
  assign funct  = ir[FN_HI:FN_LO];
  assign imm16  = ir[IMM_HI:IMM_LO];
  assign jaddr  = ir[JA_HI:JA_LO];
endmodule

// File: rtl/instr_fetch_reg.sv
// instr_fetch_reg: PC, req/ack instruction fetch FSM and IR; FETCH_TIMEOUT_EN adds a fetch timeout
module instr_fetch_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  output logic              mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_consume,
  input  logic              pc_load,
  input  logic [WORD_W-1:0] pc_load_val,
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              busy,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [IMM_W-1:0]  imm16,
  output logic [25:0]       jaddr,
  output logic              fetch_err
);
  fs_t state, next;
  logic [WORD_W-1:0] ir;
  logic acc, start, tmo;
  assign acc      = state == FS_FETCH && mem_ack;
  assign start    = next == FS_FETCH && state != FS_FETCH;
  assign pc_plus4 = pc + 32'd4;
  assign ir_valid = state == FS_VALID;
  assign busy     = state != FS_IDLE;
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign tmo = state == FS_FETCH && !mem_ack && cnt == CW'(TIMEOUT_CYCLES);
  // count FETCH cycles without an ack; the error flag is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      fetch_err <= 1'b0;
    end else begin
      cnt <= start ? '0 : (state == FS_FETCH && !mem_ack) ? cnt + 1'b1 : cnt;
      fetch_err <= fetch_err | tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign fetch_err = 1'b0;
`endif
  // next state: an ack always beats a coincident timeout
  always_comb begin
    next = state == FS_IDLE  ? (fetch_start ? FS_FETCH : FS_IDLE)
         : state == FS_FETCH ? (mem_ack ? FS_VALID : tmo ? FS_IDLE : FS_FETCH)
         : state == FS_VALID ? (ir_consume ? (fetch_start ? FS_FETCH : FS_IDLE) : FS_VALID)
         : FS_IDLE;
  end
  // state, request, address latched on FETCH entry, IR capture and PC update
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FS_IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      state   <= next;
      mem_req <= next == FS_FETCH;
      if (start) mem_addr <= pc;
      if (acc) ir <= mem_rdata;
      pc <= pc_load ? {pc_load_val[WORD_W-1:2], 2'b00} : acc ? pc_plus4 : pc;
    end
  end
  instr_fields u_fields (
    .ir(ir), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr)
  );
endmodule

// File: tb/tb_instr_fetch_reg.sv
// tb_instr_fetch_reg: directed vectors for instr_fetch_reg at two reset PCs
module tb_instr_fetch_reg;
  logic clk = 1'b0, rst, fetch_start, mem_ack, ir_consume, pc_load;
  logic [31:0] mem_rdata, pc_load_val;
  logic mem_req, ir_valid, busy, fetch_err;
  logic [31:0] mem_addr, pc, pc_plus4;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic w_req, w_valid, w_busy, w_err;
  logic [31:0] w_addr, w_pc, w_pc4;
  logic [5:0] w_opc, w_fn;
  logic [4:0] w_rs, w_rt, w_rd, w_sh;
  logic [15:0] w_imm;
  logic [25:0] w_ja;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  instr_fetch_reg dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(ir_valid), .ir_consume(ir_consume),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc(pc), .pc_plus4(pc_plus4), .busy(busy),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .jaddr(jaddr), .fetch_err(fetch_err)
  );
  instr_fetch_reg #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_valid(w_valid), .ir_consume(ir_consume),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .pc(w_pc), .pc_plus4(w_pc4), .busy(w_busy),
    .opcode(w_opc), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_sh), .funct(w_fn),
    .imm16(w_imm), .jaddr(w_ja), .fetch_err(w_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; fetch_start = 0; mem_ack = 0; ir_consume = 0; pc_load = 0;
    mem_rdata = '0; pc_load_val = '0;
    #1;
    step(); step();
    rst = 0;
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pc", pc, 0);
    chk("rst_pc_w", w_pc, 32'hFFFF_FFFC);
    chk("rst_pc4", pc_plus4, 32'd4);
    chk("rst_opc", opcode, 0);
    chk("rst_imm", imm16, 0);
    chk("rst_err", fetch_err, 0);
    fetch_start = 1; step(); fetch_start = 0;
    chk("f1_req", mem_req, 1);
    chk("f1_addr", mem_addr, 0);
    chk("f1_busy", busy, 1);
    chk("f1_valid", ir_valid, 0);
    mem_ack = 1; mem_rdata = 32'h2008_FFFF; step(); mem_ack = 0;
    chk("a1_valid", ir_valid, 1);
    chk("a1_req", mem_req, 0);
    chk("a1_opc", opcode, 6'h08);
    chk("a1_rs", rs, 0);
    chk("a1_rt", rt, 5'd8);
    chk("a1_rd", rd, 5'h1F);
    chk("a1_sh", shamt, 5'h1F);
    chk("a1_fn", funct, 6'h3F);
    chk("a1_imm", imm16, 16'hFFFF);
    chk("a1_ja", jaddr, 26'h008FFFF);
    chk("a1_pc", pc, 32'd4);
    chk("a1_pc4", pc_plus4, 32'd8);
    chk("a1_wrap", w_pc, 0);
    step(); step();
    chk("hold_valid", ir_valid, 1);
    chk("hold_imm", imm16, 16'hFFFF);
    ir_consume = 1; fetch_start = 1; step(); ir_consume = 0;
    chk("b2b_req", mem_req, 1);
    chk("b2b_addr", mem_addr, 32'd4);
    chk("b2b_valid", ir_valid, 0);
    chk("b2b_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'd4);
      chk("stall_pc", pc, 32'd4);
    end
    fetch_start = 0;
    mem_ack = 1; mem_rdata = 32'h8C22_0004; step(); mem_ack = 0;
    chk("a2_pc", pc, 32'd8);
    chk("a2_opc", opcode, 6'h23);
    chk("a2_rs", rs, 5'd1);
    chk("a2_rt", rt, 5'd2);
    chk("a2_imm", imm16, 16'h0004);
    step();
    chk("a2_pc_once", pc, 32'd8);
    ir_consume = 1; step();
    chk("cons_valid", ir_valid, 0);
    chk("cons_busy", busy, 0);
    step(); ir_consume = 0;
    chk("cons_idle", busy, 0);
    chk("cons_ir", opcode, 6'h23);
    fetch_start = 1; step(); fetch_start = 0;
    chk("f3_addr", mem_addr, 32'd8);
    pc_load = 1; pc_load_val = 32'h0000_0103; mem_ack = 1; mem_rdata = 32'h0800_0040; step();
    pc_load = 0; mem_ack = 0;
    chk("br_pc", pc, 32'h0000_0100);
    chk("br_valid", ir_valid, 1);
    chk("br_opc", opcode, 6'h02);
    chk("br_ja", jaddr, 26'h40);
    chk("br_pc_w", w_pc, 32'h0000_0100);
    ir_consume = 1; fetch_start = 1; step(); ir_consume = 0; fetch_start = 0;
    chk("f4_addr", mem_addr, 32'h0000_0100);
    pc_load = 1; pc_load_val = 32'h0000_0200; step(); pc_load = 0;
    chk("ld_pc", pc, 32'h0000_0200);
    chk("ld_addr", mem_addr, 32'h0000_0100);
    chk("ld_req", mem_req, 1);
    rst = 1; step(); rst = 0;
    chk("mrst_req", mem_req, 0);
    chk("mrst_pc", pc, 0);
    chk("mrst_pc_w", w_pc, 32'hFFFF_FFFC);
    chk("mrst_valid", ir_valid, 0);
    chk("mrst_opc", opcode, 0);
    chk("mrst_req_w", w_req, 0);
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; step(); mem_ack = 0;
    chk("late_valid", ir_valid, 0);
    chk("late_busy", busy, 0);
    chk("late_pc", pc, 0);
    chk("late_opc", opcode, 0);
    pc_load = 1; pc_load_val = 32'hFFFF_FFFF; step(); pc_load = 0;
    chk("wr_pc", pc, 32'hFFFF_FFFC);
    chk("wr_pc4", pc_plus4, 0);
    fetch_start = 1; step(); fetch_start = 0;
    chk("wr_addr", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1; mem_rdata = 32'h0000_0020; step(); mem_ack = 0;
    chk("wr_pc0", pc, 0);
    chk("wr_fn", funct, 6'h20);
    chk("wr_err", fetch_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
Fetch stage and instruction register of the multi-cycle CPU, directly upstream of the 16-bit sign extender.
- Holds the PC and runs a req/ack fetch from instruction memory.
- Latches the returned word into the IR.
- Presents decoded fields, including imm16, which feeds the sign extender's 16-bit input.
- The main control FSM drives fetch_start and ir_consume and overrides the PC on branch/jump.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset (word aligned).
TIMEOUT_CYCLES, 255, max FETCH-state cycles before fetch_err (optional feature only).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
fetch_start  in  1  control requests next instruction fetch
mem_req  out  1  instruction memory request, held until mem_ack
mem_addr  out  32  fetch address, stable while mem_req=1
mem_ack  in  1  memory returns mem_rdata this cycle
mem_rdata  in  32  instruction word
ir_valid  out  1  IR holds an unconsumed instruction
ir_consume  in  1  control has taken the current instruction
pc_load  in  1  overwrite PC (branch/jump)
pc_load_val  in  32  new PC; bits [1:0] forced to 0
pc  out  32  current PC
pc_plus4  out  32  pc + 4, combinational
busy  out  1  state != IDLE
opcode  out  6  IR[31:26]
rs  out  5  IR[25:21]
rt  out  5  IR[20:16]
rd  out  5  IR[15:11]
shamt  out  5  IR[10:6]
funct  out  6  IR[5:0]
imm16  out  16  IR[15:0], to sign extender
jaddr  out  26  IR[25:0]
fetch_err  out  1  timeout flag (0 when feature absent)

Behaviour:
- Reset values:
  - state=IDLE, pc=RESET_PC, IR=32'h0.
  - mem_req=0, mem_addr=0, ir_valid=0, fetch_err=0.
  - All field outputs are 0, since they are slices of IR.
- Reset mid-fetch abandons the request; mem_req drops the cycle after rst is sampled. A late mem_ack is ignored.
- States:
  - IDLE: fetch_start=1 -> FETCH; registers mem_addr<=pc, mem_req<=1.
  - FETCH: mem_req=1, mem_addr held.
    - mem_ack=1 -> IR<=mem_rdata, pc<=pc+4, mem_req<=0 -> VALID.
    - fetch_start is ignored in FETCH.
  - VALID: ir_valid=1.
    - ir_consume=1 and fetch_start=1 -> FETCH directly, with mem_addr<=current pc. Zero bubble.
    - ir_consume=1 only -> IDLE.
    - Otherwise hold.
- Latency: earliest mem_ack is 1 cycle after mem_req rises. IR and fields are valid the cycle after mem_ack.
- ir_consume outside VALID is ignored.
- PC update priority, any state: pc_load > fetch increment > hold.
  - If pc_load and mem_ack coincide, pc<=pc_load_val & ~3; the IR is still captured.
  - mem_addr is unaffected by pc_load during FETCH.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0). No flag.
- IR changes only on an accepted mem_ack. Fields stay stable while in VALID.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - An 8-bit (clog2(TIMEOUT_CYCLES+1)) counter clears on FETCH entry and increments each FETCH cycle without mem_ack.
  - At count==TIMEOUT_CYCLES: fetch_err<=1 (sticky until rst), mem_req<=0, state -> IDLE, IR unchanged.
  - mem_ack in the same cycle as the timeout wins: normal capture, no error.
- When undefined: no counter; fetch_err tied to 0; FETCH waits indefinitely.

Decomposition:
- Shared package cpu_pkg:
  - state encoding localparams FS_IDLE=2'd0, FS_FETCH=2'd1, FS_VALID=2'd2.
  - field bit-position constants (OPC_HI=31 ... IMM_LO=0).
  - WORD_W=32, IMM_W=16.
- One sub-module is natural: instr_fields, a pure slicer from IR to opcode/rs/rt/rd/shamt/funct/imm16/jaddr. The same slicer is reusable by the decoder.
- FSM, PC and IR stay in the top module.

Test Plan:
- Reset then fetch: rst 2 cycles, fetch_start=1 -> next cycle mem_req=1, mem_addr=0. Ack with 32'h2008FFFF next cycle -> ir_valid=1, opcode=6'h08, rt=5'd8, imm16=16'hFFFF, pc=4.
- Stalled memory: mem_ack withheld 10 cycles -> mem_req and mem_addr stable throughout. ack -> capture, pc+=4 exactly once.
- Back-to-back: in VALID, ir_consume=1 and fetch_start=1 same cycle -> next cycle FETCH with mem_addr=4, ir_valid=0, no IDLE cycle.
- Branch collision: pc_load=1, pc_load_val=32'h0000_0103, coincident with mem_ack -> pc=32'h0000_0100, IR captured, ir_valid=1.
- Wrap and reset: RESET_PC=32'hFFFF_FFFC, fetch and ack -> pc=0. Assert rst during a later FETCH -> mem_req=0 next cycle, pc=32'hFFFF_FFFC, ir_valid=0.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=4: no ack -> fetch_err=1 after 4 FETCH cycles, mem_req=0, state IDLE. Error stays set until rst.
